// File: rtl/pipe_skid_reg.sv
// Two-entry (main + skid) registered pipeline stage with valid/ready on both sides.
// Optional consumer-stall counter enabled by PIPE_SKID_REG_STALL_CNT_EN.
`default_nettype none

module pipe_skid_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // State encoding is {s_vld, m_vld}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_m_dat;
  logic [WIDTH-1:0] r_s_dat;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_m_load;
  logic w_m_from_skid;
  logic w_s_load;

  // Both handshake outputs come straight from state flops, so ready has no comb path.
  assign in_ready  = ~r_state[1];
  assign out_valid = r_state[0];
  assign out_data  = r_m_dat;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_m_load      = 1'b0;
    w_m_from_skid = 1'b0;
    w_s_load      = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_ONE;
          w_m_load    = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_m_load = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_s_load    = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_xfer) begin
          w_state_nxt   = ST_ONE;
          w_m_load      = 1'b1;
          w_m_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase

    // Flush wins over any concurrent transfer and loads nothing.
    if (flush) begin
      w_state_nxt   = ST_EMPTY;
      w_m_load      = 1'b0;
      w_m_from_skid = 1'b0;
      w_s_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data registers are enabled only on real transfers to avoid idle toggling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_dat <= '0;
    end else if (w_m_load) begin
      r_m_dat <= w_m_from_skid ? r_s_dat : in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_dat <= '0;
    end else if (w_s_load) begin
      r_s_dat <= in_data;
    end
  end

`ifdef PIPE_SKID_REG_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating; deliberately untouched by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed sequences plus random traffic,
// with a FIFO scoreboard tracking every payload accepted by the stage.
`timescale 1ns/1ps

module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        flush;
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];

  pipe_skid_reg #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush)
`ifdef PIPE_SKID_REG_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs settle at posedge+1, so at negedge everything is stable for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("mon_out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() > 0});
      chk("mon_in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < 2});
      if (out_valid && sb_q.size() > 0)
        chk("mon_out_data", {16'd0, out_data}, {16'd0, sb_q[0]});
      if (out_valid && out_ready && sb_q.size() > 0)
        void'(sb_q.pop_front());
      if (flush)
        sb_q.delete();
      else if (in_valid && in_ready)
        sb_q.push_back(in_data);
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0; flush = 1'b0;
    #12 rst = 1'b1;
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);

    // Asynchronous reset mid-cycle while holding a payload and offering another.
    in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_data = 16'h4321;
    tick();
    chk("pre_rst_data", {16'd0, out_data}, 32'h1234);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_data", {16'd0, out_data}, 32'd0);
    sb_q.delete();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    tick();

    // Streaming with 1-cycle latency.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", {16'd0, out_data}, i);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure fills main + skid, third payload held off.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hA5A5;
    tick();
    in_data = 16'h5A5A;
    tick();
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_full_data", {16'd0, out_data}, 32'hA5A5);
    in_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_data", {16'd0, out_data}, 32'hA5A5);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_drain1", {16'd0, out_data}, 32'h5A5A);
    chk("bp_drain1_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_drain2", {16'd0, out_data}, 32'hFFFF);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous in/out while ONE.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111;
    tick();
    chk("sim_one_data", {16'd0, out_data}, 32'h1111);
    in_data = 16'h2222; out_ready = 1'b1;
    tick();
    chk("sim_data", {16'd0, out_data}, 32'h2222);
    chk("sim_valid", {31'd0, out_valid}, 32'd1);
    chk("sim_skid_unused", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("sim_empty", {31'd0, out_valid}, 32'd0);

    // Flush in FULL with a payload offered and consumer ready.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0C01;
    tick();
    in_data = 16'h0C02;
    tick();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    in_data = 16'hBEEF; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_beef", {31'd0, out_valid}, 32'd0);
    end

`ifdef PIPE_SKID_REG_STALL_CNT_EN
    rst = 1'b0;
    #2 rst = 1'b1;
    sb_q.delete();
    tick();
    chk("sc_reset", {16'd0, stall_cnt}, 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0055;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("sc_five", {16'd0, stall_cnt}, 32'd5);
    repeat (65540) tick();
    chk("sc_sat", {16'd0, stall_cnt}, 32'hFFFF);
    out_ready = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sc_no_flush_clr", {16'd0, stall_cnt}, 32'hFFFF);
`endif

    // Random traffic with occasional flushes; scoreboard checks order and occupancy.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", sb_q.size(), 32'd0);
    chk("rand_idle", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
